// File: rtl/py_sched_pkg.sv
// Shared baseband definitions for the payload bit-slot scheduler.
package py_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_PAD   = 3'd4,
        ST_DONE  = 3'd5
    } py_state_e;

    localparam int unsigned FEC32_INFO = 10;
    localparam int unsigned FEC32_BLK  = 15;
    localparam int unsigned CRC16_BITS = 16;

endpackage

// File: rtl/py_sched_fec_slotcnt.sv
// Mod-15 FEC 2/3 block slot counter: 10 information slots followed by 5 parity slots.
// Only built when PY_SCHED_FEC32_EN is defined.
`ifdef PY_SCHED_FEC32_EN
module py_fec_slotcnt
    import py_sched_pkg::*;
(
    input  logic clk_6M,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    input  logic fec_en,
    output logic info_slot,
    output logic info_last,
    output logic blk_end
);

    localparam int unsigned BLKW = $clog2(FEC32_BLK);

    logic [BLKW-1:0] blk_cnt_q, blk_cnt_d;

    // Held at zero outside the payload window and whenever FEC is off.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (clr || !fec_en) begin
            blk_cnt_d = '0;
        end else if (adv) begin
            blk_cnt_d = (blk_cnt_q == BLKW'(FEC32_BLK - 1)) ? '0 : blk_cnt_q + BLKW'(1);
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign info_slot = !fec_en || (blk_cnt_q < BLKW'(FEC32_INFO));
    assign info_last = (blk_cnt_q == BLKW'(FEC32_INFO - 1));
    assign blk_end   = fec_en && (blk_cnt_q == BLKW'(FEC32_BLK - 1));

endmodule
`endif

// File: rtl/py_sched.sv
// Payload bit-slot scheduler: data, CRC16 and FEC pad windows, one slot per p_1us.
// FEC 2/3 block layout (PAD state, parity slots) is built only with PY_SCHED_FEC32_EN.
module py_sched
    import py_sched_pkg::*;
#(
    parameter int unsigned LENW = 10
) (
    input  logic            clk_6M,
    input  logic            rst,
    input  logic            p_1us,
    input  logic            start_p,
    input  logic            abort_p,
    input  logic [LENW-1:0] py_len,
    input  logic            crc_en,
    input  logic            fec32encode,
    output logic            busy,
    output logic            py_st_p,
    output logic            py_period,
    output logic            py_datperiod,
    output logic            py_crc16period,
    output logic            py_padperiod,
    output logic            daten,
    output logic            py_datvalid_p,
    output logic            fec32bk_endp,
    output logic            py_endp
);

    localparam int unsigned CNTW = LENW + 4;

    py_state_e       state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic            crc_en_q, crc_en_d;
    logic [CNTW-1:0] info_cnt_q, info_cnt_d;

    logic busy_q, busy_d;
    logic st_q, st_d;
    logic period_q, period_d;
    logic dat_q, dat_d;
    logic crcp_q, crcp_d;
    logic endp_q, endp_d;

    logic            in_period_c;
    logic            slot_c;
    logic            info_slot_c;
    logic            info_tick_c;
    logic            blk_end_c;
    logic            exhausted_c;
    logic [CNTW-1:0] data_bits_c;
    logic [CNTW-1:0] info_bits_c;
    logic [CNTW-1:0] info_nxt_c;
    py_state_e       info_end_st_c;

    assign in_period_c = (state_q == ST_DATA) || (state_q == ST_CRC) || (state_q == ST_PAD);
    assign slot_c      = p_1us && in_period_c;
    assign info_tick_c = slot_c && info_slot_c;
    assign data_bits_c = CNTW'({len_q, 3'b000});
    assign info_bits_c = data_bits_c + (crc_en_q ? CNTW'(CRC16_BITS) : CNTW'(0));
    assign info_nxt_c  = info_cnt_q + CNTW'(1);
    assign exhausted_c = (info_cnt_q == info_bits_c);

`ifdef PY_SCHED_FEC32_EN
    logic fec_q, fec_d;
    logic blk_info_last_c;
    logic pad_q, pad_d;

    always_comb begin
        fec_d = fec_q;
        if (state_q == ST_IDLE && start_p) begin
            fec_d = fec32encode;
        end
    end

    py_fec_slotcnt u_slotcnt (
        .clk_6M    (clk_6M),
        .rst       (rst),
        .clr       (!in_period_c),
        .adv       (slot_c),
        .fec_en    (fec_q),
        .info_slot (info_slot_c),
        .info_last (blk_info_last_c),
        .blk_end   (blk_end_c)
    );

    // Info bits ending on the last info slot of a block keep the current window for its parity.
    assign info_end_st_c = !fec_q ? ST_DONE : (blk_info_last_c ? state_q : ST_PAD);
    assign fec32bk_endp  = slot_c && blk_end_c;

    always_comb begin
        pad_d = (state_d == ST_PAD);
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            fec_q <= 1'b0;
            pad_q <= 1'b0;
        end else begin
            fec_q <= fec_d;
            pad_q <= pad_d;
        end
    end

    assign py_padperiod = pad_q;
`else
    logic unused_fec_c;

    assign unused_fec_c  = fec32encode;
    assign info_slot_c   = 1'b1;
    assign blk_end_c     = 1'b0;
    assign info_end_st_c = ST_DONE;
    assign fec32bk_endp  = 1'b0;
    assign py_padperiod  = 1'b0;
`endif

    // Next-state, field latching and information-slot counting.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        crc_en_d   = crc_en_q;
        info_cnt_d = info_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d  = ST_START;
                    len_d    = py_len;
                    crc_en_d = crc_en;
                end
            end
            ST_START: begin
                info_cnt_d = '0;
                if (len_q != '0) begin
                    state_d = ST_DATA;
                end else if (crc_en_q) begin
                    state_d = ST_CRC;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DATA: begin
                if (info_tick_c) begin
                    info_cnt_d = info_nxt_c;
                    if (info_nxt_c == data_bits_c) begin
                        state_d = crc_en_q ? ST_CRC : info_end_st_c;
                    end
                end else if (slot_c && exhausted_c && blk_end_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_CRC: begin
                if (info_tick_c) begin
                    info_cnt_d = info_nxt_c;
                    if (info_nxt_c == info_bits_c) begin
                        state_d = info_end_st_c;
                    end
                end else if (slot_c && exhausted_c && blk_end_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAD: begin
                if (info_tick_c) begin
                    info_cnt_d = info_nxt_c;
                end
                if (slot_c && blk_end_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_p) begin
            state_d    = ST_IDLE;
            info_cnt_d = '0;
        end
    end

    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        st_d     = (state_d == ST_START);
        period_d = (state_d == ST_DATA) || (state_d == ST_CRC) || (state_d == ST_PAD);
        dat_d    = (state_d == ST_DATA);
        crcp_d   = (state_d == ST_CRC);
        endp_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            crc_en_q   <= 1'b0;
            info_cnt_q <= '0;
            busy_q     <= 1'b0;
            st_q       <= 1'b0;
            period_q   <= 1'b0;
            dat_q      <= 1'b0;
            crcp_q     <= 1'b0;
            endp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            crc_en_q   <= crc_en_d;
            info_cnt_q <= info_cnt_d;
            busy_q     <= busy_d;
            st_q       <= st_d;
            period_q   <= period_d;
            dat_q      <= dat_d;
            crcp_q     <= crcp_d;
            endp_q     <= endp_d;
        end
    end

    assign busy           = busy_q;
    assign py_st_p        = st_q;
    assign py_period      = period_q;
    assign py_datperiod   = dat_q;
    assign py_crc16period = crcp_q;
    assign py_endp        = endp_q;
    assign daten          = period_q && info_slot_c;
    assign py_datvalid_p  = slot_c;

endmodule

// File: tb/tb_py_sched.sv
// Bench for py_sched: directed and random payloads checked slot by slot against a layout model.
module tb_py_sched;

    localparam int unsigned LENW = 10;
`ifdef PY_SCHED_FEC32_EN
    localparam bit FEC_BUILD = 1'b1;
`else
    localparam bit FEC_BUILD = 1'b0;
`endif

    logic            clk_6M = 1'b0;
    logic            rst;
    logic            p_1us;
    logic            start_p;
    logic            abort_p;
    logic [LENW-1:0] py_len;
    logic            crc_en;
    logic            fec32encode;
    logic            busy, py_st_p, py_period, py_datperiod, py_crc16period, py_padperiod;
    logic            daten, py_datvalid_p, fec32bk_endp, py_endp;

    int total = 0;
    int bad   = 0;
    int phase = 0;

    py_sched #(.LENW(LENW)) dut (
        .clk_6M         (clk_6M),
        .rst            (rst),
        .p_1us          (p_1us),
        .start_p        (start_p),
        .abort_p        (abort_p),
        .py_len         (py_len),
        .crc_en         (crc_en),
        .fec32encode    (fec32encode),
        .busy           (busy),
        .py_st_p        (py_st_p),
        .py_period      (py_period),
        .py_datperiod   (py_datperiod),
        .py_crc16period (py_crc16period),
        .py_padperiod   (py_padperiod),
        .daten          (daten),
        .py_datvalid_p  (py_datvalid_p),
        .fec32bk_endp   (fec32bk_endp),
        .py_endp        (py_endp)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: pulses drop, bit-slot strobe advances, outputs settle before sampling.
    task automatic tick();
        @(posedge clk_6M);
        #1;
        phase   = (phase == 5) ? 0 : phase + 1;
        p_1us   = (phase == 0);
        start_p = 1'b0;
        abort_p = 1'b0;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_st"},     py_st_p, 0);
        chk({tag, "_period"}, py_period, 0);
        chk({tag, "_dat"},    py_datperiod, 0);
        chk({tag, "_crc"},    py_crc16period, 0);
        chk({tag, "_pad"},    py_padperiod, 0);
        chk({tag, "_daten"},  daten, 0);
        chk({tag, "_dvalid"}, py_datvalid_p, 0);
        chk({tag, "_bkend"},  fec32bk_endp, 0);
        chk({tag, "_endp"},   py_endp, 0);
    endtask

    // Layout of 1-based slot k: typ 0=data 1=crc 2=pad, plus daten and block-end.
    function automatic void slot_model(input int k, input int d, input int tinfo, input bit crc,
                                       input bit fe, output int typ, output bit dn, output bit be);
        int pos, i;
        if (!fe) begin
            typ = (k <= d) ? 0 : 1;
            dn  = 1'b1;
            be  = 1'b0;
        end else begin
            pos = (k - 1) % 15;
            i   = ((k - 1) / 15) * 10 + ((pos < 10) ? pos + 1 : 10);
            dn  = (pos < 10);
            be  = (pos == 14);
            if (dn) begin
                typ = (i <= d) ? 0 : ((i <= tinfo) ? 1 : 2);
            end else begin
                typ = (i < d) ? 0 : ((i < tinfo) ? 1 : ((i == tinfo) ? (crc ? 1 : 0) : 2));
            end
        end
    endfunction

    task automatic run_payload(input int len, input bit crc, input bit fec,
                               input int abort_slot, input bit restart_mid);
        int d, tinfo, t, k, typ;
        bit fe, dn, be, done, aborted, restarted;
        fe    = fec && FEC_BUILD;
        d     = 8 * len;
        tinfo = d + (crc ? 16 : 0);
        t     = fe ? 15 * ((tinfo + 9) / 10) : tinfo;
        py_len      = LENW'(len);
        crc_en      = crc;
        fec32encode = fec;
        start_p     = 1'b1;
        tick();
        py_len      = LENW'($urandom);
        crc_en      = ~crc;
        fec32encode = ~fec;
        chk("st_p", py_st_p, 1);
        chk("st_busy", busy, 1);
        chk("st_period", py_period, 0);
        chk("st_dvalid", py_datvalid_p, 0);
        tick();
        k = 1;
        done = 1'b0;
        aborted = 1'b0;
        restarted = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            if (k <= t) begin
                slot_model(k, d, tinfo, crc, fe, typ, dn, be);
                chk("period", py_period, 1);
                chk("busy", busy, 1);
                chk("datperiod", py_datperiod, 32'(typ == 0));
                chk("crcperiod", py_crc16period, 32'(typ == 1));
                chk("padperiod", py_padperiod, 32'(typ == 2));
                chk("daten", daten, 32'(dn));
                chk("datvalid", py_datvalid_p, 32'(p_1us));
                chk("bkend", fec32bk_endp, 32'(p_1us && be));
                chk("no_endp", py_endp, 0);
                if (restart_mid && !restarted && k == 3) begin
                    start_p   = 1'b1;
                    restarted = 1'b1;
                end
                if (p_1us) begin
                    if (k == abort_slot) begin
                        abort_p = 1'b1;
                        aborted = 1'b1;
                    end
                    k++;
                end
                tick();
                if (aborted) begin
                    chk_quiet("abort");
                    for (int j = 0; j < 12; j++) begin
                        tick();
                        chk("abort_noendp", py_endp, 0);
                        chk("abort_idle", busy, 0);
                    end
                    done = 1'b1;
                end
            end else begin
                chk("endp", py_endp, 1);
                chk("end_busy", busy, 1);
                chk("end_period", py_period, 0);
                chk("end_daten", daten, 0);
                tick();
                chk("endp_once", py_endp, 0);
                chk("idle_busy", busy, 0);
                done = 1'b1;
            end
        end
        chk("timeout", 32'(done), 1);
        repeat ($urandom_range(0, 6)) tick();
    endtask

    initial begin
        rst         = 1'b1;
        p_1us       = 1'b0;
        start_p     = 1'b0;
        abort_p     = 1'b0;
        py_len      = '0;
        crc_en      = 1'b0;
        fec32encode = 1'b0;
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();
        chk_quiet("post_reset");

        run_payload(1, 1'b1, 1'b0, 0, 1'b0);
        run_payload(1, 1'b1, 1'b1, 0, 1'b0);
        run_payload(0, 1'b0, 1'b0, 0, 1'b0);
        run_payload(0, 1'b0, 1'b1, 0, 1'b0);
        run_payload(2, 1'b0, 1'b1, 0, 1'b0);
        run_payload(5, 1'b1, 1'b1, 0, 1'b0);
        run_payload(5, 1'b0, 1'b1, 0, 1'b0);
        run_payload(0, 1'b1, 1'b1, 0, 1'b0);

        run_payload(1, 1'b1, 1'b0, 13, 1'b0);
        run_payload(1, 1'b1, 1'b0, 0, 1'b0);
        run_payload(3, 1'b1, 1'b1, 0, 1'b1);

        start_p = 1'b1;
        abort_p = 1'b1;
        py_len  = LENW'(4);
        tick();
        chk("abort_wins_busy", busy, 0);
        chk("abort_wins_st", py_st_p, 0);

        py_len      = LENW'(2);
        crc_en      = 1'b1;
        fec32encode = 1'b1;
        start_p     = 1'b1;
        tick();
        repeat (20) tick();
        chk("midrst_active", busy, 1);
        rst = 1'b1;
        tick();
        chk_quiet("midrst");
        rst = 1'b0;
        tick();
        chk_quiet("midrst_after");
        run_payload(2, 1'b1, 1'b0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int rl, rc, rf;
            rl = $urandom_range(0, 12);
            rc = $urandom_range(0, 1);
            rf = $urandom_range(0, 1);
            run_payload(rl, rc[0], rf[0], 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
